// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares one synchronous single-port SRAM between the instruction-fetch
// requester and the data (load/store) requester. One transaction is in
// flight at a time: IDLE accepts a request and fires the SRAM strobe in the
// same cycle, WAIT counts out the SRAM read latency and returns the response
// to the requester that owns the transaction.
//
// Optional feature macro: SRAM_ARB_RR_EN
//   defined   -> round-robin between requesters on simultaneous requests
//   undefined -> data always beats inst on simultaneous requests
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   inst_req / inst_addr        fetch request (read only)
//   inst_addr_ok                fetch accepted this cycle
//   inst_data_ok / inst_rdata   fetch response
//   data_req / data_we /        data request; data_we == 0 is a read,
//   data_addr / data_wdata      any nonzero byte-enable pattern is a write
//   data_addr_ok                data request accepted this cycle
//   data_data_ok / data_rdata   data response (load data or write done)
//   sram_en / sram_we /         SRAM access strobe, byte enables,
//   sram_addr / sram_wdata      address and write data
//   sram_rdata                  SRAM read data, valid SRAM_LAT cycles after
//                               the sram_en cycle
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
  parameter  int ADDR_W   = 32,
  parameter  int DATA_W   = 32,
  parameter  int SRAM_LAT = 1,
  localparam int BE_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,

  input  logic              data_req,
  input  logic [BE_W-1:0]   data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,

  output logic              sram_en,
  output logic [BE_W-1:0]   sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic { S_IDLE, S_WAIT } state_e;
  typedef enum logic { OWN_INST, OWN_DATA } owner_e;

  // SRAM_LAT is at most 4, so three bits hold the countdown.
  localparam int            CNT_W   = 3;
  localparam logic [CNT_W-1:0] LAT_VAL = CNT_W'(SRAM_LAT);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  owner_e              owner_q, owner_d;
  logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
`ifdef SRAM_ARB_RR_EN
  owner_e              last_q, last_d;
`endif

  logic pick_data;
  logic grant_inst;
  logic grant_data;

  // Which requester wins if the arbiter grants this cycle.
`ifdef SRAM_ARB_RR_EN
  // On a tie, the requester not granted last time goes first.
  assign pick_data = data_req && (!inst_req || (last_q == OWN_INST));
`else
  assign pick_data = data_req;
`endif

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
`ifdef SRAM_ARB_RR_EN
    last_d       = last_q;
`endif
    grant_inst   = 1'b0;
    grant_data   = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The grant is combinational from the requests, so it is also gated
        // by resetn: nothing may be accepted while reset is held.
        if (resetn && (inst_req || data_req)) begin
          grant_data = pick_data;
          grant_inst = !pick_data;
          owner_d    = pick_data ? OWN_DATA : OWN_INST;
          cnt_d      = LAT_VAL;
          state_d    = S_WAIT;
`ifdef SRAM_ARB_RR_EN
          last_d     = pick_data ? OWN_DATA : OWN_INST;
`endif
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Count of 1 marks the cycle the SRAM output is valid.
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          if (owner_q == OWN_DATA) begin
            data_data_ok = 1'b1;
            data_rdata_d = sram_rdata;
          end else begin
            inst_data_ok = 1'b1;
            inst_rdata_d = sram_rdata;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge value and evaluation order cannot matter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      owner_q      <= OWN_INST;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
`ifdef SRAM_ARB_RR_EN
      last_q       <= OWN_INST;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
`ifdef SRAM_ARB_RR_EN
      last_q       <= last_d;
`endif
    end
  end

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;

  // Fetches never write, so their byte enables and write data are forced to 0.
  assign sram_en    = grant_inst || grant_data;
  assign sram_we    = grant_data ? data_we : '0;
  assign sram_addr  = grant_data ? data_addr : (grant_inst ? inst_addr : '0);
  assign sram_wdata = grant_data ? data_wdata : '0;

  // The response cycle forwards the SRAM output directly so the data lines
  // up with data_ok; afterwards the captured copy holds it.
  assign inst_rdata = inst_data_ok ? sram_rdata : inst_rdata_q;
  assign data_rdata = data_data_ok ? sram_rdata : data_rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_port_arbiter
//
// Two arbiter instances share clk and resetn: index 0 uses SRAM_LAT=1,
// index 1 uses SRAM_LAT=3. A transaction-level model tracks, per instance,
// the cycle number of the outstanding accept; the response is due exactly
// SRAM_LAT cycles after it. Directed stimulus carries hand-computed literal
// expectations for the key scenarios.
// -----------------------------------------------------------------------------
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;

  logic        inst_req     [2];
  logic [31:0] inst_addr    [2];
  logic        inst_addr_ok [2];
  logic        inst_data_ok [2];
  logic [31:0] inst_rdata   [2];
  logic        data_req     [2];
  logic [3:0]  data_we      [2];
  logic [31:0] data_addr    [2];
  logic [31:0] data_wdata   [2];
  logic        data_addr_ok [2];
  logic        data_data_ok [2];
  logic [31:0] data_rdata   [2];
  logic        sram_en      [2];
  logic [3:0]  sram_we      [2];
  logic [31:0] sram_addr    [2];
  logic [31:0] sram_wdata   [2];
  logic [31:0] sram_rdata   [2];

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .SRAM_LAT(1)) u_lat1 (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req[0]), .inst_addr(inst_addr[0]),
    .inst_addr_ok(inst_addr_ok[0]), .inst_data_ok(inst_data_ok[0]),
    .inst_rdata(inst_rdata[0]),
    .data_req(data_req[0]), .data_we(data_we[0]), .data_addr(data_addr[0]),
    .data_wdata(data_wdata[0]), .data_addr_ok(data_addr_ok[0]),
    .data_data_ok(data_data_ok[0]), .data_rdata(data_rdata[0]),
    .sram_en(sram_en[0]), .sram_we(sram_we[0]), .sram_addr(sram_addr[0]),
    .sram_wdata(sram_wdata[0]), .sram_rdata(sram_rdata[0])
  );

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .SRAM_LAT(3)) u_lat3 (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req[1]), .inst_addr(inst_addr[1]),
    .inst_addr_ok(inst_addr_ok[1]), .inst_data_ok(inst_data_ok[1]),
    .inst_rdata(inst_rdata[1]),
    .data_req(data_req[1]), .data_we(data_we[1]), .data_addr(data_addr[1]),
    .data_wdata(data_wdata[1]), .data_addr_ok(data_addr_ok[1]),
    .data_data_ok(data_data_ok[1]), .data_rdata(data_rdata[1]),
    .sram_en(sram_en[1]), .sram_we(sram_we[1]), .sram_addr(sram_addr[1]),
    .sram_wdata(sram_wdata[1]), .sram_rdata(sram_rdata[1])
  );

  always #5 clk = ~clk;

`ifdef SRAM_ARB_RR_EN
  localparam bit RR_BUILD = 1'b1;
`else
  localparam bit RR_BUILD = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level model: one outstanding access per instance, identified
  // by the cycle number it was accepted in.
  // ---------------------------------------------------------------------------
  int          cyc = 0;
  bit          m_busy   [2];
  int          m_acc    [2];
  bit          m_data   [2];   // 1: outstanding access belongs to data port
  bit          m_last_d [2];   // 1: last grant went to data port
  logic [31:0] m_hold_i [2] = '{32'h0, 32'h0};
  logic [31:0] m_hold_d [2] = '{32'h0, 32'h0};

  task automatic model_step(input int k);
    int          lat;
    logic        e_iao, e_ido, e_dao, e_ddo, e_en;
    logic [3:0]  e_we;
    logic [31:0] e_addr, e_wdata;
    bit          win_data;
    string       p;
    lat     = (k == 0) ? 1 : 3;
    p       = $sformatf("cyc%0d.lat%0d", cyc, lat);
    e_iao   = 1'b0; e_ido = 1'b0; e_dao = 1'b0; e_ddo = 1'b0; e_en = 1'b0;
    e_we    = 4'h0; e_addr = 32'h0; e_wdata = 32'h0;
    if (!resetn) begin
      m_busy[k]   = 1'b0;
      m_last_d[k] = 1'b0;
      m_hold_i[k] = 32'h0;
      m_hold_d[k] = 32'h0;
    end else if (m_busy[k] && (cyc == m_acc[k] + lat)) begin
      if (m_data[k]) begin
        e_ddo       = 1'b1;
        m_hold_d[k] = sram_rdata[k];
      end else begin
        e_ido       = 1'b1;
        m_hold_i[k] = sram_rdata[k];
      end
      m_busy[k] = 1'b0;
    end else if (!m_busy[k] && (inst_req[k] || data_req[k])) begin
      if (inst_req[k] && data_req[k])
        win_data = RR_BUILD ? !m_last_d[k] : 1'b1;
      else
        win_data = data_req[k];
      e_en = 1'b1;
      if (win_data) begin
        e_dao   = 1'b1;
        e_we    = data_we[k];
        e_addr  = data_addr[k];
        e_wdata = data_wdata[k];
      end else begin
        e_iao   = 1'b1;
        e_addr  = inst_addr[k];
      end
      m_busy[k]   = 1'b1;
      m_acc[k]    = cyc;
      m_data[k]   = win_data;
      m_last_d[k] = win_data;
    end
    check_bit ({p, ".inst_addr_ok"}, inst_addr_ok[k], e_iao);
    check_bit ({p, ".inst_data_ok"}, inst_data_ok[k], e_ido);
    check_bit ({p, ".data_addr_ok"}, data_addr_ok[k], e_dao);
    check_bit ({p, ".data_data_ok"}, data_data_ok[k], e_ddo);
    check_bit ({p, ".sram_en"},      sram_en[k],      e_en);
    check_word({p, ".sram_we"},      32'(sram_we[k]), 32'(e_we));
    check_word({p, ".inst_rdata"},   inst_rdata[k],   m_hold_i[k]);
    check_word({p, ".data_rdata"},   data_rdata[k],   m_hold_d[k]);
    if (e_en) begin
      check_word({p, ".sram_addr"},  sram_addr[k],  e_addr);
      check_word({p, ".sram_wdata"}, sram_wdata[k], e_wdata);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
    cyc++;
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      inst_req[k]   = 1'b0; inst_addr[k]  = 32'h0;
      data_req[k]   = 1'b0; data_we[k]    = 4'h0;
      data_addr[k]  = 32'h0; data_wdata[k] = 32'h0;
      sram_rdata[k] = 32'h0;
    end
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    // Single fetch, latency 1.
    tick(); inst_req[0] = 1'b1; inst_addr[0] = 32'h1c00_0000; mid();
    check_bit ("fetch.addr_ok",  inst_addr_ok[0], 1'b1);
    check_bit ("fetch.sram_en",  sram_en[0],      1'b1);
    check_word("fetch.sram_addr", sram_addr[0],   32'h1c00_0000);
    tick(); inst_req[0] = 1'b0; sram_rdata[0] = 32'h0280_0405; mid();
    check_bit ("fetch.data_ok",  inst_data_ok[0], 1'b1);
    check_word("fetch.rdata",    inst_rdata[0],   32'h0280_0405);
    check_bit ("fetch.no_dresp", data_data_ok[0], 1'b0);
    tick(); sram_rdata[0] = 32'h0; mid();
    check_bit ("fetch.ok_pulse", inst_data_ok[0], 1'b0);
    check_word("fetch.hold",     inst_rdata[0],   32'h0280_0405);

    // Simultaneous requests: data first, inst served at the next IDLE.
    tick();
    inst_req[0] = 1'b1; inst_addr[0] = 32'h1c00_0004;
    data_req[0] = 1'b1; data_we[0] = 4'h0; data_addr[0] = 32'h0000_0100;
    mid();
    check_bit ("coll.data_addr_ok", data_addr_ok[0], 1'b1);
    check_bit ("coll.inst_wait",    inst_addr_ok[0], 1'b0);
    check_word("coll.sram_addr",    sram_addr[0],    32'h0000_0100);
    tick(); data_req[0] = 1'b0; sram_rdata[0] = 32'haaaa_0001; mid();
    check_bit ("coll.data_data_ok", data_data_ok[0], 1'b1);
    check_word("coll.data_rdata",   data_rdata[0],   32'haaaa_0001);
    check_bit ("coll.bubble",       inst_addr_ok[0], 1'b0);
    tick(); sram_rdata[0] = 32'h0; mid();
    check_bit ("coll.inst_addr_ok", inst_addr_ok[0], 1'b1);
    check_word("coll.inst_sram_addr", sram_addr[0],  32'h1c00_0004);
    tick(); inst_req[0] = 1'b0; sram_rdata[0] = 32'hbbbb_0002; mid();
    check_bit ("coll.inst_data_ok", inst_data_ok[0], 1'b1);
    check_word("coll.inst_rdata",   inst_rdata[0],   32'hbbbb_0002);
    check_word("coll.data_hold",    data_rdata[0],   32'haaaa_0001);
    tick(); sram_rdata[0] = 32'h0;

    // Partial store.
    tick();
    data_req[0] = 1'b1; data_we[0] = 4'b0011;
    data_addr[0] = 32'h0000_0200; data_wdata[0] = 32'hdead_beef;
    mid();
    check_bit ("store.addr_ok", data_addr_ok[0], 1'b1);
    check_word("store.we",      32'(sram_we[0]), 32'h3);
    check_word("store.wdata",   sram_wdata[0],   32'hdead_beef);
    tick(); data_req[0] = 1'b0; data_we[0] = 4'h0; data_wdata[0] = 32'h0; mid();
    check_bit ("store.data_ok", data_data_ok[0], 1'b1);
    check_word("store.we_off",  32'(sram_we[0]), 32'h0);
    tick();

    // Latency 3 load with a fetch queued behind it.
    tick(); data_req[1] = 1'b1; data_addr[1] = 32'h0000_0300; mid();
    check_bit("lat3.addr_ok", data_addr_ok[1], 1'b1);
    tick();
    data_req[1] = 1'b0; inst_req[1] = 1'b1; inst_addr[1] = 32'h1c00_0100;
    for (int i = 1; i <= 3; i++) begin
      sram_rdata[1] = 32'h1111_1111 * i;
      mid();
      check_bit($sformatf("lat3.no_iaok_T%0d", i), inst_addr_ok[1], 1'b0);
      check_bit($sformatf("lat3.no_daok_T%0d", i), data_addr_ok[1], 1'b0);
      check_bit($sformatf("lat3.data_ok_T%0d", i), data_data_ok[1], i == 3);
      tick();
    end
    sram_rdata[1] = 32'h0; mid();
    check_word("lat3.rdata_hold",   data_rdata[1],   32'h3333_3333);
    check_bit ("lat3.next_accept",  inst_addr_ok[1], 1'b1);
    tick(); inst_req[1] = 1'b0;
    tick();
    tick(); sram_rdata[1] = 32'h4444_4444; mid();
    check_bit ("lat3.fetch_ok",    inst_data_ok[1], 1'b1);
    check_word("lat3.fetch_rdata", inst_rdata[1],   32'h4444_4444);
    tick(); sram_rdata[1] = 32'h0;

    // Reset in the middle of a latency-3 fetch.
    tick(); inst_req[1] = 1'b1; inst_addr[1] = 32'h1c00_0200; mid();
    check_bit("rst.addr_ok", inst_addr_ok[1], 1'b1);
    tick(); inst_req[1] = 1'b0; resetn = 1'b0; #1;
    check_bit ("rst.inst_data_ok", inst_data_ok[1], 1'b0);
    check_bit ("rst.sram_en",      sram_en[1],      1'b0);
    check_word("rst.sram_we",      32'(sram_we[1]), 32'h0);
    check_word("rst.inst_rdata",   inst_rdata[1],   32'h0);
    check_word("rst.data_rdata",   data_rdata[1],   32'h0);
    tick(); tick(); resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); sram_rdata[1] = 32'h5555_5555; mid();
      check_bit($sformatf("rst.dropped_%0d", i), inst_data_ok[1], 1'b0);
    end
    tick(); sram_rdata[1] = 32'h0; inst_req[1] = 1'b1; inst_addr[1] = 32'h1c00_0300;
    mid();
    check_bit("rst.new_addr_ok", inst_addr_ok[1], 1'b1);
    tick(); inst_req[1] = 1'b0;
    tick();
    tick(); sram_rdata[1] = 32'h6666_6666; mid();
    check_bit ("rst.new_data_ok", inst_data_ok[1], 1'b1);
    check_word("rst.new_rdata",   inst_rdata[1],   32'h6666_6666);
    tick(); sram_rdata[1] = 32'h0;

    // Both requests held continuously on the latency-1 instance.
    tick();
    inst_req[0] = 1'b1; inst_addr[0] = 32'h1c00_0400;
    data_req[0] = 1'b1; data_we[0] = 4'h0; data_addr[0] = 32'h0000_0400;
    for (int i = 0; i < 8; i++) begin
      logic exp_d, exp_i;
      exp_d = (i % 2 == 0) && (RR_BUILD ? (i % 4 == 0) : 1'b1);
      exp_i = (i % 2 == 0) && !exp_d;
      mid();
      check_bit($sformatf("prio.data_grant_%0d", i), data_addr_ok[0], exp_d);
      check_bit($sformatf("prio.inst_grant_%0d", i), inst_addr_ok[0], exp_i);
      tick();
    end
    inst_req[0] = 1'b0; data_req[0] = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
